// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner and initiator side of the iterative divider handshake (EX stage).
// Optional macro HILO_SIGNED_DIV_EN enables signed DIV (magnitude conversion + sign fix-up).
module hilo_div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [2:0]       ex_op,
  input  logic [WIDTH-1:0] ex_rs,
  input  logic [WIDTH-1:0] ex_rt,
  output logic [WIDTH-1:0] rd_data,
  output logic             pipe_stall,
  output logic             div_in_valid,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_out_valid
);

  localparam logic [2:0] OpDiv  = 3'd1;
  localparam logic [2:0] OpDivu = 3'd2;
  localparam logic [2:0] OpMthi = 3'd3;
  localparam logic [2:0] OpMtlo = 3'd4;
  localparam logic [2:0] OpMfhi = 3'd5;
  localparam logic [2:0] OpMflo = 3'd6;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
  logic [WIDTH-1:0] mag_rs, mag_rt, quo_fix, rem_fix;
  logic             is_div, rt_zero, launch;

  assign is_div  = ex_valid & ((ex_op == OpDiv) | (ex_op == OpDivu));
  assign rt_zero = (ex_rt == '0);
  assign launch  = (state_q == StIdle) & is_div & ~rt_zero;

`ifdef HILO_SIGNED_DIV_EN
  logic sgn_rs, sgn_rt, neg_quo_q, neg_rem_q;

  assign sgn_rs  = (ex_op == OpDiv) & ex_rs[WIDTH-1];
  assign sgn_rt  = (ex_op == OpDiv) & ex_rt[WIDTH-1];
  // Negating the most negative value wraps to itself, which is its correct magnitude.
  assign mag_rs  = sgn_rs ? -ex_rs : ex_rs;
  assign mag_rt  = sgn_rt ? -ex_rt : ex_rt;
  assign quo_fix = neg_quo_q ? -div_quotient : div_quotient;
  assign rem_fix = neg_rem_q ? -div_remainder : div_remainder;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (launch) begin
      neg_quo_q <= sgn_rs ^ sgn_rt;
      neg_rem_q <= sgn_rs;
    end
  end
`else
  assign mag_rs  = ex_rs;
  assign mag_rt  = ex_rt;
  assign quo_fix = div_quotient;
  assign rem_fix = div_remainder;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (div_out_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    if (state_q == StIdle && ex_valid) begin
      case (ex_op)
        OpDiv, OpDivu: begin
          if (rt_zero) begin
            hi_d = ex_rs;
            lo_d = '1;
          end else begin
            dividend_d = mag_rs;
            divisor_d  = mag_rt;
          end
        end
        OpMthi:  hi_d = ex_rs;
        OpMtlo:  lo_d = ex_rs;
        default: ;
      endcase
    end else if (state_q == StWait && div_out_valid) begin
      lo_d = quo_fix;
      hi_d = rem_fix;
    end
  end

  always_comb begin
    div_in_valid = (state_q == StIssue);
    pipe_stall   = launch | (state_q == StIssue) | ((state_q == StWait) & ~div_out_valid);
    rd_data      = '0;
    if (state_q == StIdle && ex_valid) begin
      if (ex_op == OpMfhi) rd_data = hi_q;
      else if (ex_op == OpMflo) rd_data = lo_q;
    end
  end

  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: vector table, corner sequences and random ops
// against an arithmetic reference model of HI/LO.
module tb_hilo_div_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ex_valid;
  logic [2:0]   ex_op;
  logic [W-1:0] ex_rs, ex_rt;
  logic [W-1:0] rd_data;
  logic         pipe_stall, div_in_valid;
  logic [W-1:0] div_dividend, div_divisor, div_remainder, div_quotient;
  logic         div_out_valid;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_div_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .rd_data      (rd_data),
    .pipe_stall   (pipe_stall),
    .div_in_valid (div_in_valid),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_remainder(div_remainder),
    .div_quotient (div_quotient),
    .div_out_valid(div_out_valid)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    int           lat;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } div_vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: architectural result of a DIV/DIVU plus the operands the divider should see.
  task automatic ref_div(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                         output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic [W-1:0] dvd, output logic [W-1:0] dvs);
    longint a, b, q, r;
    logic [63:0] t;
    bit sgn;
`ifdef HILO_SIGNED_DIV_EN
    sgn = (op == 3'd1);
`else
    sgn = 1'b0;
`endif
    if (rt == '0) begin
      hi = rs; lo = '1; dvd = '0; dvs = '0;
    end else if (sgn) begin
      a = longint'($signed(rs));
      b = longint'($signed(rt));
      q = a / b;
      r = a % b;
      t = q; lo = t[W-1:0];
      t = r; hi = t[W-1:0];
      t = (a < 0) ? -a : a; dvd = t[W-1:0];
      t = (b < 0) ? -b : b; dvs = t[W-1:0];
    end else begin
      lo = rs / rt; hi = rs % rt; dvd = rs; dvs = rt;
    end
  endtask

  task automatic read_hilo(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo);
    @(negedge clk); ex_valid = 1'b1; ex_op = 3'd5; #1;
    chk({tag, " mfhi"}, rd_data, hi);
    chk({tag, " mfhi stall"}, {31'd0, pipe_stall}, '0);
    @(negedge clk); ex_op = 3'd6; #1;
    chk({tag, " mflo"}, rd_data, lo);
    @(negedge clk); ex_valid = 1'b0; ex_op = 3'd0;
  endtask

  // Drives one DIV/DIVU through EX and plays the divider with the given latency.
  task automatic run_div(input string tag, input logic [2:0] op, input logic [W-1:0] rs,
                         input logic [W-1:0] rt, input int lat, input logic [W-1:0] dvd,
                         input logic [W-1:0] dvs, input logic [W-1:0] hi,
                         input logic [W-1:0] lo);
    logic [W-1:0] sdvd, sdvs;
    bit bad;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = op; ex_rs = rs; ex_rt = rt; #1;
    if (rt == '0) begin
      chk({tag, " zero stall"}, {31'd0, pipe_stall}, '0);
      chk({tag, " zero start"}, {31'd0, div_in_valid}, '0);
      @(negedge clk); ex_valid = 1'b0; #1;
      chk({tag, " zero no start"}, {31'd0, div_in_valid}, '0);
    end else begin
      chk({tag, " T stall"}, {31'd0, pipe_stall}, 32'd1);
      chk({tag, " T start"}, {31'd0, div_in_valid}, '0);
      @(negedge clk); #1;
      chk({tag, " issue start"}, {31'd0, div_in_valid}, 32'd1);
      chk({tag, " issue stall"}, {31'd0, pipe_stall}, 32'd1);
      chk({tag, " dividend"}, div_dividend, dvd);
      chk({tag, " divisor"}, div_divisor, dvs);
      sdvd = div_dividend; sdvs = div_divisor;
      bad = 1'b0;
      for (int i = 1; i < lat; i++) begin
        @(negedge clk); #1;
        if (div_in_valid !== 1'b0 || pipe_stall !== 1'b1 || div_dividend !== sdvd) bad = 1'b1;
      end
      chk({tag, " wait stall/start"}, {31'd0, bad}, '0);
      @(negedge clk);
      div_out_valid = 1'b1;
      div_quotient = (sdvs != 0) ? sdvd / sdvs : '1;
      div_remainder = (sdvs != 0) ? sdvd % sdvs : sdvd;
      #1;
      chk({tag, " D stall"}, {31'd0, pipe_stall}, '0);
      @(negedge clk);
      div_out_valid = 1'b0; ex_valid = 1'b0;
    end
    m_hi = hi; m_lo = lo;
    read_hilo(tag, m_hi, m_lo);
  endtask

  div_vec_t vecs[$];

  initial begin
    logic [W-1:0] h, l, dd, ds;
    logic [2:0] op;
    logic [W-1:0] rs, rt;
    int lat;
    logic [W-1:0] exp_rd;

    ex_valid = 0; ex_op = 0; ex_rs = 0; ex_rt = 0;
    div_out_valid = 0; div_quotient = 0; div_remainder = 0;
    m_hi = 0; m_lo = 0;
    rst_n = 1'b0; #1;
    chk("reset stall", {31'd0, pipe_stall}, '0);
    chk("reset start", {31'd0, div_in_valid}, '0);
    chk("reset rd_data", rd_data, '0);
    chk("reset dividend", div_dividend, '0);
    chk("reset divisor", div_divisor, '0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    read_hilo("reset hilo", '0, '0);

    vecs.push_back('{3'd2, 32'd100, 32'd7, 33, 32'd100, 32'd7, 32'd2, 32'd14});
`ifdef HILO_SIGNED_DIV_EN
    vecs.push_back('{3'd1, 32'hFFFFFFF9, 32'd2, 4, 32'd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{3'd1, 32'h80000000, 32'hFFFFFFFF, 3, 32'h80000000, 32'd1, 32'd0,
                     32'h80000000});
    vecs.push_back('{3'd1, 32'd9, 32'hFFFFFFFC, 2, 32'd9, 32'd4, 32'd1, 32'hFFFFFFFE});
`else
    vecs.push_back('{3'd1, 32'hFFFFFFF9, 32'd2, 4, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC});
    vecs.push_back('{3'd1, 32'h80000000, 32'hFFFFFFFF, 3, 32'h80000000, 32'hFFFFFFFF,
                     32'h80000000, 32'd0});
`endif
    vecs.push_back('{3'd2, 32'd55, 32'd0, 1, 32'd0, 32'd0, 32'd55, 32'hFFFFFFFF});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'd1, 1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF});
    foreach (vecs[i])
      run_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].lat,
              vecs[i].dvd, vecs[i].dvs, vecs[i].hi, vecs[i].lo);

    // MTHI/MTLO then back-to-back MFHI/MFLO, then a spurious out_valid in IDLE.
    @(negedge clk); ex_valid = 1; ex_op = 3'd3; ex_rs = 32'hA5A5A5A5; #1;
    chk("mthi stall", {31'd0, pipe_stall}, '0);
    @(negedge clk); ex_op = 3'd4; ex_rs = 32'h5A5A5A5A; #1;
    chk("mtlo stall", {31'd0, pipe_stall}, '0);
    m_hi = 32'hA5A5A5A5; m_lo = 32'h5A5A5A5A;
    read_hilo("mt/mf", m_hi, m_lo);
    @(negedge clk); div_out_valid = 1; div_quotient = 32'h1234; div_remainder = 32'h5678;
    @(negedge clk); div_out_valid = 0;
    read_hilo("spurious ov", m_hi, m_lo);

    // Reset in the middle of WAIT abandons the divide.
    @(negedge clk); ex_valid = 1; ex_op = 3'd2; ex_rs = 32'd1000; ex_rt = 32'd3;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; ex_valid = 0; #1;
    chk("rst wait stall", {31'd0, pipe_stall}, '0);
    chk("rst wait start", {31'd0, div_in_valid}, '0);
    chk("rst wait dividend", div_dividend, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); div_out_valid = 1; div_quotient = 32'd333; div_remainder = 32'd1;
    @(negedge clk); div_out_valid = 0;
    m_hi = 0; m_lo = 0;
    read_hilo("rst wait hilo", m_hi, m_lo);

    // Random ops against the reference model.
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom;
      case ($urandom_range(0, 3))
        0: rt = '0;
        1: rt = 32'($urandom_range(1, 20));
        2: rt = -32'($urandom_range(1, 20));
        default: rt = $urandom;
      endcase
      lat = $urandom_range(1, 8);
      if (op == 3'd1 || op == 3'd2) begin
        ref_div(op, rs, rt, h, l, dd, ds);
        run_div($sformatf("rnd%0d div", n), op, rs, rt, lat, dd, ds, h, l);
      end else begin
        @(negedge clk); ex_valid = 1; ex_op = op; ex_rs = rs; ex_rt = rt; #1;
        exp_rd = (op == 3'd5) ? m_hi : (op == 3'd6) ? m_lo : '0;
        chk($sformatf("rnd%0d rd_data", n), rd_data, exp_rd);
        chk($sformatf("rnd%0d stall", n), {31'd0, pipe_stall}, '0);
        if (op == 3'd3) m_hi = rs;
        if (op == 3'd4) m_lo = rs;
        @(negedge clk); ex_valid = 0;
      end
    end
    read_hilo("final", m_hi, m_lo);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hilo_div_ctrl.md
# hilo_div_ctrl

Initiator side of the iterative divider handshake, placed in the EX stage next to the HI/LO registers. It decodes DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX and launches the divider with a one-cycle `in_valid` pulse. It holds the pipeline stalled until the divider's `out_valid`, then applies signed fix-up and writes HI (remainder) and LO (quotient). It also serves MFHI/MFLO reads.

## Interface
- `WIDTH`, 32, datapath width of operands, HI, LO.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX-stage instruction valid.
- `ex_op` in 3: 0 NOP, 1 DIV, 2 DIVU, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 reserved (treated as NOP).
- `ex_rs` in WIDTH: rs operand (dividend / MT source).
- `ex_rt` in WIDTH: rt operand (divisor).
- `rd_data` out WIDTH: MFHI/MFLO result.
- `pipe_stall` out 1: freeze pipeline.
- `div_in_valid` out 1: start pulse to divider.
- `div_dividend`, `div_divisor` out WIDTH: unsigned operands to divider.
- `div_remainder`, `div_quotient` in WIDTH: unsigned divider results.
- `div_out_valid` in 1: divider result valid, one-cycle pulse.

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE**
  - `ex_valid` with DIV/DIVU and `ex_rt != 0`: register the operands into `div_dividend`/`div_divisor`. For DIV these are magnitudes; |0x80000000| = 0x80000000. Register `neg_q` = sign(rs)^sign(rt) and `neg_r` = sign(rs); both are 0 for DIVU. Go to ISSUE.
  - DIV/DIVU with `ex_rt == 0`: no launch, no stall. HI <= `ex_rs`, LO <= all-ones. Stay in IDLE.
  - MTHI: HI <= `ex_rs`. MTLO: LO <= `ex_rs`. Single cycle, no stall.
  - MFHI/MFLO: `rd_data` = HI/LO combinationally. Otherwise `rd_data` = 0.
- **ISSUE**
  - `div_in_valid` = 1 for exactly this cycle. Go to WAIT.
- **WAIT**
  - `div_in_valid` = 0. Operand registers are held.
  - On `div_out_valid`: LO <= `neg_q` ? -quotient : quotient, and HI <= `neg_r` ? -remainder : remainder, both mod 2^WIDTH. Go to IDLE.
- All `ex_*` inputs are ignored outside IDLE; the pipeline is frozen, so EX still holds the DIV.
- `div_out_valid` outside WAIT is ignored.
- `pipe_stall` = (IDLE & `ex_valid` & DIV/DIVU & `ex_rt != 0`) | ISSUE | (WAIT & !`div_out_valid`).
- Arithmetic is modulo 2^WIDTH; there is no overflow flag. 0x80000000 / -1 gives LO = 0x80000000, HI = 0.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, HI = LO = 0, `div_in_valid` = 0, `div_dividend` = `div_divisor` = 0.
  - `pipe_stall` = 0 and `rd_data` = 0 while `ex_valid` = 0.
- Cycle T: DIV is in EX in IDLE; `pipe_stall` = 1.
- T+1: ISSUE, `div_in_valid` = 1.
- The divider completes at cycle D, the cycle where `div_out_valid` = 1.
  - In D, `pipe_stall` = 0, so the DIV leaves EX at the end of D.
  - HI/LO hold the new values from D+1.
- An MFHI/MFLO entering EX at D+1 reads the new value, so no forwarding is needed.
- Total latency is divider latency + 1 (the ISSUE cycle). The block makes no assumption about the divider's cycle count.
- A reset during ISSUE/WAIT abandons the operation: HI/LO go to 0 and no write occurs. The divider shares `rst_n`.

## Configuration
- `HILO_SIGNED_DIV_EN`
  - Defined: DIV does the magnitude conversion and sign fix-up above.
  - Undefined: DIV behaves exactly as DIVU; `neg_q` = `neg_r` = 0 and operands pass through raw. The negation logic is not synthesized.

## Test plan
- Reset mid-WAIT: assert `rst_n` = 0 during WAIT -> immediately state IDLE, HI = LO = 0, `pipe_stall` = 0, `div_in_valid` = 0, and no later HI/LO write.
- DIVU 100 / 7 with a 33-cycle divider model -> `div_in_valid` high exactly 1 cycle, `pipe_stall` high from T through the cycle before `div_out_valid`, then HI = 2, LO = 14.
- DIV -7 / 2 (`HILO_SIGNED_DIV_EN` defined) -> divider sees 7 / 2, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Without the macro -> divider sees 0xFFFFFFF9 / 2, LO = 0x7FFFFFFC, HI = 1.
- DIV 0x80000000 / 0xFFFFFFFF (signed) -> LO = 0x80000000, HI = 0.
- DIVU 55 / 0 -> no stall, no `div_in_valid`; next cycle HI = 55, LO = 0xFFFFFFFF.
- MTHI 0xA5A5A5A5, MTLO 0x5A5A5A5A, then MFHI, MFLO in consecutive cycles -> `rd_data` = 0xA5A5A5A5 then 0x5A5A5A5A, `pipe_stall` = 0 throughout. A spurious `div_out_valid` in IDLE leaves HI/LO unchanged.
